// File: rtl/sim_ctrl_pkg.sv
// rtl/sim_ctrl_pkg.sv - shared types, constants and helpers for sim_ctrl
package sim_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_STALL   = 3'd5
    } status_e;

    // tohost value that signals success; any other odd value is a failure code
    localparam logic [31:0] TOHOST_PASS         = 32'h1;
    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h8000_1000;

    // Number of set bits in a retire vector of up to four channels
    function automatic logic [2:0] popcount(input logic [3:0] bits);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, bits[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sim_ctrl_rst_sync.sv
// rtl/sim_ctrl_rst_sync.sv - reset synchronizer, asynchronous assert and synchronous deassert
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n
);

    logic [STAGES-1:0] chain;

    // Shift ones in after release; any assertion clears the whole chain at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = chain[STAGES-1];

endmodule

// File: rtl/sim_ctrl.sv
// rtl/sim_ctrl.sv - simulation control: core reset, cycle/retire counters, tohost, timeout and stall watchdogs
module sim_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned STALL_CYCLES   = 1000,
    parameter int unsigned N_RET          = 1,
    parameter logic [31:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_RET-1:0] retire_valid,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             core_rst_n,
    output logic [2:0]       status,
    output logic             done,
    output logic             pass,
    output logic [30:0]      exit_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [31:0]      HOLD_LAST  = 32'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LIM  = CNT_W'(STALL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    status_e           state;
    status_e           state_next;
    logic              sync_rst_n;
    logic [31:0]       hold_cnt;
    logic [CNT_W-1:0]  idle_cnt;
    logic [CNT_W-1:0]  idle_next;
    logic [CNT_W-1:0]  cycle_next;
    logic [CNT_W:0]    ret_sum;
    logic [3:0]        ret_vec;
    logic [2:0]        ret_pop;
    logic              tohost_hit;
    logic              timeout_hit;
    logic              stall_hit;
    logic              term_next;

    rst_sync #(.STAGES(2)) u_rst_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_rst_n (sync_rst_n)
    );

    // Event detection and saturating counter increments for the current RUN cycle
    always_comb begin
        ret_vec              = '0;
        ret_vec[N_RET-1:0]   = retire_valid;
        ret_pop              = popcount(ret_vec);
        ret_sum              = {1'b0, retire_cnt} + {{(CNT_W-2){1'b0}}, ret_pop};
        cycle_next           = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + 1'b1;
        if (|retire_valid) begin
            idle_next = '0;
        end else begin
            idle_next = (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + 1'b1;
        end
        tohost_hit  = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt == TO_LAST);
        stall_hit   = (STALL_CYCLES != 0) && (idle_next == STALL_LIM);
    end

    // Next-state logic: hold until the counted release, then watch for a terminating event
    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: begin
                if (sync_rst_n && (hold_cnt == HOLD_LAST)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tohost_hit) begin
                    state_next = (st_data == TOHOST_PASS) ? ST_PASS : ST_FAIL;
                end else if (timeout_hit) begin
                    state_next = ST_TIMEOUT;
                end else if (stall_hit) begin
                    state_next = ST_STALL;
                end
            end
            default: state_next = state;
        endcase
        term_next = (state_next == ST_PASS) || (state_next == ST_FAIL) ||
                    (state_next == ST_TIMEOUT) || (state_next == ST_STALL);
    end

    // State register; the raw reset is used so assertion takes effect immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Counters and registered outputs; counters only advance while in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            idle_cnt   <= '0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            exit_code  <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            core_rst_n <= (state_next != ST_RESET);
            done       <= term_next;
            pass       <= (state_next == ST_PASS);
            if (state == ST_RESET && sync_rst_n) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (state == ST_RUN) begin
                cycle_cnt  <= cycle_next;
                retire_cnt <= ret_sum[CNT_W] ? CNT_MAX : ret_sum[CNT_W-1:0];
                idle_cnt   <= idle_next;
                if (tohost_hit) begin
                    exit_code <= st_data[31:1];
                end
            end
        end
    end

    assign status = state;

endmodule

// File: tb/tb_sim_ctrl.sv
// tb/tb_sim_ctrl.sv - randomized self-checking bench for sim_ctrl against a behavioural model
module tb_sim_ctrl;

    localparam int          RST_CYCLES     = 4;
    localparam int          TIMEOUT_CYCLES = 50;
    localparam int          STALL_CYCLES   = 10;
    localparam int          N_RET          = 2;
    localparam logic [31:0] TOHOST         = 32'h8000_1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_RET-1:0] retire_valid = '0;
    logic             st_valid = 1'b0;
    logic [31:0]      st_addr = '0;
    logic [31:0]      st_data = '0;
    logic             core_rst_n;
    logic [2:0]       status;
    logic             done;
    logic             pass;
    logic [30:0]      exit_code;
    logic [31:0]      cycle_cnt;
    logic [31:0]      retire_cnt;

    sim_ctrl #(
        .RST_CYCLES     (RST_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .STALL_CYCLES   (STALL_CYCLES),
        .N_RET          (N_RET),
        .TOHOST_ADDR    (TOHOST),
        .CNT_W          (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .retire_valid (retire_valid),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .core_rst_n   (core_rst_n),
        .status       (status),
        .done         (done),
        .pass         (pass),
        .exit_code    (exit_code),
        .cycle_cnt    (cycle_cnt),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: status code, edges since release, plain integer counters
    int    m_status;
    int    m_since_rel;
    longint m_cycle;
    longint m_ret;
    int    m_idle;
    longint m_exit;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_status = 0; m_since_rel = 0; m_cycle = 0; m_ret = 0; m_idle = 0; m_exit = 0;
    endtask

    task automatic model_step();
        bit hit;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hit = st_valid && (st_addr == TOHOST) && st_data[0];
        if (m_status == 0) begin
            m_since_rel++;
            if (m_since_rel == RST_CYCLES + 2) m_status = 1;
        end else if (m_status == 1) begin
            m_cycle++;
            m_ret += $countones(retire_valid);
            m_idle = (retire_valid != 0) ? 0 : m_idle + 1;
            if (hit) begin
                m_status = (st_data == 32'h1) ? 2 : 3;
                m_exit   = longint'(st_data >> 1);
            end else if (m_cycle == TIMEOUT_CYCLES) begin
                m_status = 4;
            end else if (m_idle == STALL_CYCLES) begin
                m_status = 5;
            end
        end
    endtask

    task automatic compare_all();
        check("status",     status,     m_status);
        check("done",       done,       m_status >= 2);
        check("pass",       pass,       m_status == 2);
        check("core_rst_n", core_rst_n, m_status != 0);
        check("cycle_cnt",  cycle_cnt,  m_cycle);
        check("retire_cnt", retire_cnt, m_ret);
        check("exit_code",  exit_code,  m_exit);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_inputs(input bit allow_hit, input bit busy);
        retire_valid = busy ? N_RET'($urandom_range(1, 3)) : N_RET'($urandom_range(0, 3));
        st_valid     = 1'($urandom_range(0, 1));
        st_data      = $urandom;
        if ($urandom_range(0, 3) == 0) st_data = 32'h1;
        if (allow_hit && $urandom_range(0, 7) == 0) begin
            st_addr = TOHOST;
        end else begin
            st_addr = $urandom;
            if (st_addr == TOHOST) st_addr = st_addr ^ 32'h4;
        end
    endtask

    task automatic quiet();
        retire_valid = '0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    endtask

    // Assert reset asynchronously mid-cycle, then release and time the core reset
    task automatic reset_release();
        int n;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        rand_inputs(1, 1);
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        while (core_rst_n !== 1'b1 && n < 20) begin
            rand_inputs(1, 1);
            tick();
            n++;
        end
        check("release_edges", n, RST_CYCLES + 2);
        quiet();
    endtask

    initial begin
        int n;
        model_reset();
        @(negedge clk);
        compare_all();

        // Release timing and pass store followed by an ignored fail store
        reset_release();
        for (int i = 0; i < 5; i++) begin rand_inputs(0, 1); tick(); end
        st_valid = 1'b1; st_addr = TOHOST; st_data = 32'h1;
        tick();
        check("t2_pass_status", status, 2);
        st_data = 32'h7;
        for (int i = 0; i < 3; i++) tick();
        check("t2_exit_sticky", exit_code, 0);

        // bit0-clear store ignored, then fail store
        reset_release();
        st_valid = 1'b1; st_addr = TOHOST; st_data = 32'h6;
        tick();
        check("t3_ignored", status, 1);
        st_data = 32'h7;
        tick();
        check("t3_fail_exit", exit_code, 3);
        for (int i = 0; i < 3; i++) begin rand_inputs(1, 0); tick(); end

        // Timeout with constant retirement, then frozen
        reset_release();
        for (int i = 0; i < 70; i++) begin rand_inputs(0, 1); tick(); end
        check("t4_timeout", status, 4);
        check("t4_frozen", cycle_cnt, TIMEOUT_CYCLES);

        // Stall after ten idle edges
        reset_release();
        for (int i = 0; i < 5; i++) begin retire_valid = 2'b11; tick(); end
        retire_valid = 2'b00;
        n = 0;
        while (status != 3'd5 && n < 15) begin tick(); n++; end
        check("t5_idle_edges", n, STALL_CYCLES);
        check("t5_retire", retire_cnt, 10);
        for (int i = 0; i < 10; i++) begin rand_inputs(1, 1); tick(); end

        // Pass beats timeout on the same cycle; then reset mid-PASS
        reset_release();
        n = 0;
        while (m_cycle < TIMEOUT_CYCLES - 1 && n < 60) begin rand_inputs(0, 1); tick(); n++; end
        st_valid = 1'b1; st_addr = TOHOST; st_data = 32'h1;
        tick();
        check("t6_prio", status, 2);
        quiet();
        tick();
        tick();
        reset_release();

        // Fully random runs with occasional tohost stores and idle stretches
        for (int r = 0; r < 6; r++) begin
            reset_release();
            for (int i = 0; i < 70; i++) begin
                rand_inputs(1, 1'($urandom_range(0, 1)));
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
